mult_arbiter: RTL and testbench

//   Shares one sequential multiplier (start/busy/result handshake, 16-bit operands, 16-bit result)

---
 rtl/mult_arbiter_pkg.sv | 15 +
 rtl/mult_arbiter_rr_pick.sv | 37 +++
 rtl/mult_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mult_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// Shared types and constants for the multiplier arbiter.
package mult_arbiter_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ARM   = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    // Operand/result width of the shared multiplier
    localparam int DW_DEFAULT = 16;

endpackage : mult_arbiter_pkg

// File: rtl/mult_arbiter_rr_pick.sv
// Round-robin winner selection: first set request bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] win,
    output logic             any
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    // Walk the requests cyclically from ptr, marking only the first one found
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N_REQ)) begin
                sum = sum - (PW+1)'(N_REQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule : rr_pick

// File: rtl/mult_arbiter.sv
// Shares one sequential multiplier between N_REQ requesters with round-robin grant.
// State | meaning
// IDLE  | waiting for a request; grant and operand capture happen on leaving
// ISSUE | start pulse is on the bus; multiplier busy is not trusted yet
// ARM   | waiting for busy to rise, bounded by ARM_TMO cycles (timeout sets err_o)
// WAIT  | multiplier running; completion when busy falls
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DW      = DW_DEFAULT,
    parameter int ARM_TMO = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*DW-1:0] a_i,
    input  logic [N_REQ*DW-1:0] b_i,
    output logic [N_REQ-1:0]    gnt_o,
    output logic [N_REQ-1:0]    done_o,
    output logic [DW-1:0]       y_o,
    output logic                busy_o,
    output logic                err_o,
    output logic                mul_start_o,
    output logic [DW-1:0]       mul_a_o,
    output logic [DW-1:0]       mul_b_o,
    input  logic                mul_busy_i,
    input  logic [DW-1:0]       mul_y_i
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(ARM_TMO + 1);

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     cur_q, cur_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic [DW-1:0]     y_q, y_d;
    logic              err_q, err_d;
    logic              start_q, start_d;
    logic [DW-1:0]     mul_a_q, mul_a_d;
    logic [DW-1:0]     mul_b_q, mul_b_d;

    logic [N_REQ-1:0]  pick_win;
    logic              pick_any;
    logic [PW-1:0]     pick_idx;
    logic [DW-1:0]     pick_a;
    logic [DW-1:0]     pick_b;
    logic [CW-1:0]     cnt_inc;
    logic              tmo_hit;
    logic              complete;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req (req_i),
        .ptr (ptr_q),
        .win (pick_win),
        .any (pick_any)
    );

    // Convert the one-hot winner to an index and select its operands
    always_comb begin
        pick_idx = '0;
        pick_a   = '0;
        pick_b   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_win[i]) begin
                pick_idx = PW'(i);
                pick_a   = a_i[i*DW +: DW];
                pick_b   = b_i[i*DW +: DW];
            end
        end
    end

    // Completion: busy fell in WAIT, or busy never rose within the ARM window
    always_comb begin
        cnt_inc  = cnt_q + CW'(1);
        tmo_hit  = (state_q == S_ARM) && !mul_busy_i && (cnt_inc == CW'(ARM_TMO));
        complete = tmo_hit || ((state_q == S_WAIT) && !mul_busy_i);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_any) state_d = S_ISSUE;
            S_ISSUE: state_d = S_ARM;
            S_ARM: begin
                if (mul_busy_i) begin
                    state_d = S_WAIT;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT:  if (!mul_busy_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        y_d     = y_q;
        err_d   = err_q;
        start_d = 1'b0;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_win;
                    cur_d   = pick_idx;
                    start_d = 1'b1;
                    mul_a_d = pick_a;
                    mul_b_d = pick_b;
                end
            end
            S_ISSUE: cnt_d = '0;
            S_ARM:   if (!mul_busy_i) cnt_d = cnt_inc;
            default: ;
        endcase
        if (complete) begin
            y_d    = mul_y_i;
            done_d = gnt_q;
            gnt_d  = '0;
            ptr_d  = (cur_q == PW'(N_REQ - 1)) ? '0 : cur_q + PW'(1);
            if (tmo_hit) begin
                err_d = 1'b1;
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            y_q     <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            y_q     <= y_d;
            err_q   <= err_d;
            start_q <= start_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign y_o         = y_q;
    assign busy_o      = (state_q != S_IDLE);
    assign err_o       = err_q;
    assign mul_start_o = start_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;

endmodule : mult_arbiter

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural sequential multiplier.
module tb_mult_arbiter;

    localparam int N_REQ   = 4;
    localparam int DW      = 16;
    localparam int ARM_TMO = 4;
    localparam int MUL_LAT = 3;

    logic                clk;
    logic                reset;
    logic [N_REQ-1:0]    req_i;
    logic [N_REQ*DW-1:0] a_i;
    logic [N_REQ*DW-1:0] b_i;
    logic [N_REQ-1:0]    gnt_o;
    logic [N_REQ-1:0]    done_o;
    logic [DW-1:0]       y_o;
    logic                busy_o;
    logic                err_o;
    logic                mul_start_o;
    logic [DW-1:0]       mul_a_o;
    logic [DW-1:0]       mul_b_o;
    logic                mul_busy_i;
    logic [DW-1:0]       mul_y_i;

    logic                stub;
    logic                m_busy;
    logic [7:0]          m_cnt;
    logic [DW-1:0]       m_acc;
    logic [DW-1:0]       m_y;

    int vectors;
    int miscompares;

    mult_arbiter #(
        .N_REQ   (N_REQ),
        .DW      (DW),
        .ARM_TMO (ARM_TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .gnt_o       (gnt_o),
        .done_o      (done_o),
        .y_o         (y_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .mul_start_o (mul_start_o),
        .mul_a_o     (mul_a_o),
        .mul_b_o     (mul_b_o),
        .mul_busy_i  (mul_busy_i),
        .mul_y_i     (mul_y_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sequential multiplier: busy rises the cycle after start, result valid as busy falls
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0;
            m_cnt  <= '0;
            m_acc  <= '0;
            m_y    <= '0;
        end else if (mul_start_o && !m_busy) begin
            m_busy <= 1'b1;
            m_cnt  <= 8'(MUL_LAT);
            m_acc  <= mul_a_o * mul_b_o;
        end else if (m_busy) begin
            if (m_cnt == 8'd1) begin
                m_busy <= 1'b0;
                m_y    <= m_acc;
            end else begin
                m_cnt <= m_cnt - 8'd1;
            end
        end
    end

    assign mul_busy_i = stub ? 1'b0 : m_busy;
    assign mul_y_i    = stub ? 16'h1234 : m_y;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        a_i[k*DW +: DW] = a;
        b_i[k*DW +: DW] = b;
    endtask

    // Run until a done pulse (bounded), then check who was served and with what
    task automatic run_op(input string tag, input logic [3:0] exp_done, input logic [15:0] exp_y,
                          input int exp_starts, input logic [3:0] clr_mask, input bit drop_in_wait,
                          output int lat);
        int cyc      = 0;
        int starts   = 0;
        int start_at = -1000;
        bit seen     = 1'b0;
        logic [3:0] g = '0;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (mul_start_o) begin
                starts++;
                start_at = cyc;
            end
            if (drop_in_wait && mul_busy_i && cyc >= start_at + 2) req_i = '0;
            if (done_o != '0) seen = 1'b1;
            else if (gnt_o != '0) g = gnt_o;
        end
        lat = cyc - start_at;
        if (seen) req_i = req_i & ~clr_mask;
        chk({tag, " done"}, 32'(done_o), 32'(exp_done));
        chk({tag, " y"}, 32'(y_o), 32'(exp_y));
        chk({tag, " starts"}, 32'(starts), 32'(exp_starts));
        chk({tag, " gnt"}, 32'(g), 32'(exp_done));
        chk({tag, " gnt_at_done"}, 32'(gnt_o), 32'd0);
    endtask

    initial begin
        int lat;
        int cnt;
        vectors     = 0;
        miscompares = 0;
        stub        = 1'b0;
        reset       = 1'b0;
        req_i       = 4'b1111;
        a_i         = '0;
        b_i         = '0;
        set_ops(0, 16'd3, 16'd3);

        // Reset with every requester asking
        repeat (3) @(negedge clk);
        chk("rst gnt", 32'(gnt_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst y", 32'(y_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst err", 32'(err_o), 32'd0);
        chk("rst start", 32'(mul_start_o), 32'd0);
        chk("rst mul_a", 32'(mul_a_o), 32'd0);
        chk("rst mul_b", 32'(mul_b_o), 32'd0);

        // Release: requester 0 wins first
        reset = 1'b1;
        @(negedge clk);
        chk("rel gnt", 32'(gnt_o), 32'b0001);
        chk("rel start", 32'(mul_start_o), 32'd1);
        chk("rel mul_a", 32'(mul_a_o), 32'd3);
        chk("rel busy", 32'(busy_o), 32'd1);
        req_i = '0;
        run_op("rel_op", 4'b0001, 16'd9, 0, 4'b0000, 1'b0, lat);

        // Single requester 2, 8*8
        set_ops(2, 16'd8, 16'd8);
        req_i = 4'b0100;
        run_op("single", 4'b0100, 16'd64, 1, 4'b0100, 1'b0, lat);
        @(negedge clk);
        chk("single done_width", 32'(done_o), 32'd0);
        chk("single gnt_after", 32'(gnt_o), 32'd0);

        // Serve requester 3 so the pointer wraps to 0
        set_ops(3, 16'd6, 16'd6);
        req_i = 4'b1000;
        run_op("wrap", 4'b1000, 16'd36, 1, 4'b1000, 1'b0, lat);

        // Round robin with 1011 held: order 0,1,3,0
        set_ops(0, 16'd3, 16'd3);
        set_ops(1, 16'd4, 16'd4);
        set_ops(3, 16'd6, 16'd6);
        req_i = 4'b1011;
        run_op("rr0", 4'b0001, 16'd9,  1, 4'b0000, 1'b0, lat);
        run_op("rr1", 4'b0010, 16'd16, 1, 4'b0000, 1'b0, lat);
        run_op("rr3", 4'b1000, 16'd36, 1, 4'b0000, 1'b0, lat);
        run_op("rr0b", 4'b0001, 16'd9, 1, 4'b1111, 1'b0, lat);

        // Requester 1 drops its request during WAIT
        set_ops(1, 16'd5, 16'd5);
        req_i = 4'b0010;
        run_op("drop", 4'b0010, 16'd25, 1, 4'b0000, 1'b1, lat);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (gnt_o != '0 || mul_start_o) cnt++;
        end
        chk("drop not_reserved", 32'(cnt), 32'd0);

        // ARM timeout with the multiplier stubbed idle
        chk("tmo err_before", 32'(err_o), 32'd0);
        stub = 1'b1;
        set_ops(0, 16'd7, 16'd7);
        req_i = 4'b0001;
        run_op("tmo", 4'b0001, 16'h1234, 1, 4'b0001, 1'b0, lat);
        chk("tmo latency", 32'(lat), 32'(ARM_TMO + 1));
        chk("tmo err", 32'(err_o), 32'd1);
        stub = 1'b0;

        // err_o stays set across a normal operation
        set_ops(0, 16'd3, 16'd5);
        req_i = 4'b0001;
        run_op("sticky", 4'b0001, 16'd15, 1, 4'b0001, 1'b0, lat);
        chk("sticky err", 32'(err_o), 32'd1);

        // Reset while the multiplier is running
        set_ops(2, 16'd2, 16'd9);
        req_i = 4'b0100;
        cnt = 0;
        while (!mul_busy_i && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("mid busy_seen", 32'(mul_busy_i), 32'd1);
        @(negedge clk);
        chk("mid in_wait", 32'(busy_o), 32'd1);
        reset = 1'b0;
        req_i = '0;
        #1;
        chk("mid done", 32'(done_o), 32'd0);
        chk("mid gnt", 32'(gnt_o), 32'd0);
        chk("mid busy", 32'(busy_o), 32'd0);
        chk("mid err", 32'(err_o), 32'd0);
        chk("mid y", 32'(y_o), 32'd0);
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o != '0) cnt++;
        end
        chk("mid no_done", 32'(cnt), 32'd0);
        reset = 1'b1;
        req_i = 4'b0100;
        run_op("after_rst", 4'b0100, 16'd18, 1, 4'b0100, 1'b0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mult_arbiter
